board_mem_arbiter: RTL and testbench

- Shares the single 64-entry x 4-bit board memory between the four board clients: control, move validator, datapath (init/move update) and view (renderer).
- Replaces the fixed 2-bit grant selector with request/grant handshaking, round-robin fairness and per-client read-data return.
- Sits between the clients and the board RAM. The board RAM has 1-cycle read latency.

---
 rtl/board_pkg.sv | 19 +
 rtl/board_rr_pick.sv | 35 +++
 rtl/board_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and arbiter state encoding for the board memory subsystem.
package board_pkg;

    localparam int unsigned REQ_CONTROL   = 0;
    localparam int unsigned REQ_VALIDATOR = 1;
    localparam int unsigned REQ_DATAPATH  = 2;
    localparam int unsigned REQ_VIEW      = 3;

    localparam int unsigned BOARD_N_REQ  = 4;
    localparam int unsigned BOARD_ADDR_W = 6;
    localparam int unsigned PIECE_W      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/board_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module board_rr_pick
    import board_pkg::*;
#(
    parameter int unsigned N_REQ = BOARD_N_REQ,
    parameter int unsigned IDX_W = $clog2(BOARD_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = '0;
        // Last owner is visited last, which gives the fairness guarantee.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) begin
            pick_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Round-robin request/grant arbiter in front of the 1-cycle-latency board RAM.
// Optional grant hold limit enabled by defining BOARD_ARB_HOLD_LIMIT_EN.
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter int unsigned N_REQ  = BOARD_N_REQ,
    parameter int unsigned ADDR_W = BOARD_ADDR_W,
    parameter int unsigned DATA_W = PIECE_W
`ifdef BOARD_ARB_HOLD_LIMIT_EN
    ,
    parameter int unsigned MAX_HOLD = 64
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr_flat,
    input  logic [N_REQ*DATA_W-1:0]   wdata_flat,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [N_REQ-1:0]  pick_c;
    logic [IDX_W-1:0]  pick_idx_c;
    logic              own_req_c;
    logic              own_we_c;
    logic [ADDR_W-1:0] own_addr_c;
    logic [DATA_W-1:0] own_wdata_c;
    logic              hold_hit_c;

    board_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick_c),
        .idx_o  (pick_idx_c)
    );

    // Current owner's request fields.
    assign own_req_c   = req[owner_q];
    assign own_we_c    = we[owner_q];
    assign own_addr_c  = addr_flat[32'(owner_q)*ADDR_W +: ADDR_W];
    assign own_wdata_c = wdata_flat[32'(owner_q)*DATA_W +: DATA_W];

`ifdef BOARD_ARB_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Counts grant cycles; the MAX_HOLD-th grant cycle is the last one.
    assign hold_hit_c = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == ARB_GRANT) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_hit_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        rvalid_d  = '0;
        rd_pend_d = 1'b0;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        if (rd_pend_q) begin
            rdata_d = mem_rdata;
        end

        case (state_q)
            ARB_IDLE, ARB_RELEASE: begin
                if (|req) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_c;
                    owner_d = pick_idx_c;
                    ptr_d   = pick_idx_c;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ARB_GRANT: begin
                mem_addr  = own_addr_c;
                mem_wdata = own_wdata_c;
                if (own_req_c) begin
                    mem_we = own_we_c;
                    if (!own_we_c) begin
                        rd_pend_d = 1'b1;
                        rvalid_d  = gnt_q;
                    end
                end
                if (!own_req_c || hold_hit_c) begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            busy_q    <= 1'b0;
            rvalid_q  <= '0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rvalid_q  <= rvalid_d;
            rd_pend_q <= rd_pend_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    // RAM data passes through in its valid cycle, otherwise the last value is held.
    assign rdata  = rd_pend_q ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: directed table, corner sequences, random vs model.
module tb_board_mem_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 4;
`ifdef BOARD_ARB_HOLD_LIMIT_EN
    localparam int unsigned TB_MAX_HOLD = 4;
`endif

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req, we;
    logic [NR*AW-1:0]  addr_flat;
    logic [NR*DW-1:0]  wdata_flat;
    logic [NR-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic [1:0]        owner;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    int n_vec;
    int n_err;

    board_mem_arbiter #(
        .N_REQ  (NR),
        .ADDR_W (AW),
        .DATA_W (DW)
`ifdef BOARD_ARB_HOLD_LIMIT_EN
        ,
        .MAX_HOLD (TB_MAX_HOLD)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr_flat  (addr_flat),
        .wdata_flat (wdata_flat),
        .gnt        (gnt),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .owner      (owner),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM: synchronous write, one-cycle registered read.
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        req        = '0;
        we         = '0;
        addr_flat  = '0;
        wdata_flat = '0;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = 9;
        if ($countones(v) == 1) begin
            for (int i = 0; i < int'(NR); i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0] req;
        logic [3:0] we;
        logic [5:0] addr;
        logic [3:0] wd;
        logic [3:0] gnt;
        logic [3:0] rv;
        logic [3:0] rd;
        logic       mwe;
        logic [1:0] own;
        logic       busy;
        logic [5:0] maddr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] w, input logic [5:0] a,
                                input logic [3:0] d, input logic [3:0] g, input logic [3:0] rv,
                                input logic [3:0] rd, input logic mw, input logic [1:0] ow,
                                input logic b, input logic [5:0] ma);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wd = d; v.gnt = g; v.rv = rv; v.rd = rd;
        v.mwe = mw; v.own = ow; v.busy = b; v.maddr = ma;
        return v;
    endfunction

    vec_t tbl [17];

    // ---------------- reference model ----------------
    int            m_own;
    bit            m_rel;
    int            m_ptr;
    int            m_shown;
    bit            m_pv;
    int            m_pc;
    logic [DW-1:0] m_pd;
    logic [DW-1:0] m_rd;
    int            m_hold;
    logic [DW-1:0] shadow [64];

    task automatic model_reset();
        m_own = -1; m_rel = 1'b0; m_ptr = NR - 1; m_shown = 0;
        m_pv = 1'b0; m_pc = 0; m_pd = '0; m_rd = '0; m_hold = 0;
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return addr_flat[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wd_of(input int i);
        return wdata_flat[i*DW +: DW];
    endfunction

    task automatic model_check();
        logic [NR-1:0] eg, erv;
        logic          emwe;
        logic [AW-1:0] ema;
        logic [DW-1:0] emwd;
        eg = '0; erv = '0; emwe = 1'b0; ema = '0; emwd = '0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            emwe = req[m_own] & we[m_own];
            ema  = addr_of(m_own);
            emwd = wd_of(m_own);
        end
        if (m_pv) erv[m_pc] = 1'b1;
        chk("rnd_gnt",    32'(gnt),       32'(eg));
        chk("rnd_busy",   32'(busy),      32'((m_own >= 0) || m_rel));
        chk("rnd_owner",  32'(owner),     32'(m_shown));
        chk("rnd_rvalid", 32'(rvalid),    32'(erv));
        chk("rnd_rdata",  32'(rdata),     32'(m_pv ? m_pd : m_rd));
        chk("rnd_mem_we", 32'(mem_we),    32'(emwe));
        chk("rnd_maddr",  32'(mem_addr),  32'(ema));
        chk("rnd_mwdata", 32'(mem_wdata), 32'(emwd));
    endtask

    task automatic model_step(input bit rst);
        bit            npv = 1'b0;
        int            npc = 0;
        logic [DW-1:0] npd = '0;
        bit            lim = 1'b0;
        if (m_own >= 0) begin
            if (req[m_own]) begin
                if (we[m_own]) shadow[addr_of(m_own)] = wd_of(m_own);
                else begin
                    npv = 1'b1; npc = m_own; npd = shadow[addr_of(m_own)];
                end
            end
            m_hold++;
`ifdef BOARD_ARB_HOLD_LIMIT_EN
            lim = (m_hold == int'(TB_MAX_HOLD));
`endif
            if (!req[m_own] || lim) begin
                m_own = -1; m_rel = 1'b1;
            end
        end else begin
            m_rel = 1'b0;
            for (int k = 1; k <= int'(NR); k++) begin
                int c = (m_ptr + k) % NR;
                if (m_own < 0 && req[c]) begin
                    m_own = c; m_ptr = c; m_shown = c; m_hold = 0;
                end
            end
        end
        if (m_pv) m_rd = m_pd;
        m_pv = npv; m_pc = npc; m_pd = npd;
        if (rst) model_reset();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rq;
        int         cnt [NR];
        int         order [$];
        int         gaps [$];
        int         lens [$];
        logic [3:0] prev_g, g;
        int         zrun, blen;
        int         exp_order [5];
        bit         rst;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        mem_rdata = '0;

        //        req    we     addr  wd     gnt    rv     rd    mwe own busy maddr
        tbl[0]  = mk(4'h4, 4'h0, 6'd0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 6'd0);
        tbl[1]  = mk(4'h4, 4'h4, 6'd9, 4'h6, 4'h4, 4'h0, 4'h0, 1, 2, 1, 6'd9);
        tbl[2]  = mk(4'h4, 4'h0, 6'd9, 4'h0, 4'h4, 4'h0, 4'h0, 0, 2, 1, 6'd9);
        tbl[3]  = mk(4'h4, 4'h4, 6'd5, 4'hA, 4'h4, 4'h4, 4'h6, 1, 2, 1, 6'd5);
        tbl[4]  = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h4, 4'h0, 4'h6, 0, 2, 1, 6'd0);
        tbl[5]  = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h0, 4'h0, 4'h6, 0, 2, 1, 6'd0);
        tbl[6]  = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h0, 4'h0, 4'h6, 0, 2, 0, 6'd0);
        tbl[7]  = mk(4'h8, 4'h0, 6'd5, 4'h0, 4'h0, 4'h0, 4'h6, 0, 2, 0, 6'd0);
        tbl[8]  = mk(4'h8, 4'h0, 6'd5, 4'h0, 4'h8, 4'h0, 4'h6, 0, 3, 1, 6'd5);
        tbl[9]  = mk(4'hA, 4'h2, 6'd7, 4'h3, 4'h8, 4'h8, 4'hA, 0, 3, 1, 6'd7);
        tbl[10] = mk(4'h2, 4'h2, 6'd7, 4'h3, 4'h8, 4'h8, 4'h0, 0, 3, 1, 6'd7);
        tbl[11] = mk(4'h2, 4'h2, 6'd7, 4'h3, 4'h0, 4'h0, 4'h0, 0, 3, 1, 6'd0);
        tbl[12] = mk(4'h2, 4'h2, 6'd7, 4'h3, 4'h2, 4'h0, 4'h0, 1, 1, 1, 6'd7);
        tbl[13] = mk(4'h2, 4'h0, 6'd7, 4'h0, 4'h2, 4'h0, 4'h0, 0, 1, 1, 6'd7);
        tbl[14] = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h2, 4'h2, 4'h3, 0, 1, 1, 6'd0);
        tbl[15] = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h0, 4'h0, 4'h3, 0, 1, 1, 6'd0);
        tbl[16] = mk(4'h0, 4'h0, 6'd0, 4'h0, 4'h0, 4'h0, 4'h3, 0, 1, 0, 6'd0);

        reset_dut();
        for (int r = 0; r < 17; r++) begin
            req        = tbl[r].req;
            we         = tbl[r].we;
            addr_flat  = {4{tbl[r].addr}};
            wdata_flat = {4{tbl[r].wd}};
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", r),    32'(gnt),      32'(tbl[r].gnt));
            chk($sformatf("tbl%0d_rvalid", r), 32'(rvalid),   32'(tbl[r].rv));
            chk($sformatf("tbl%0d_rdata", r),  32'(rdata),    32'(tbl[r].rd));
            chk($sformatf("tbl%0d_mem_we", r), 32'(mem_we),   32'(tbl[r].mwe));
            chk($sformatf("tbl%0d_owner", r),  32'(owner),    32'(tbl[r].own));
            chk($sformatf("tbl%0d_busy", r),   32'(busy),     32'(tbl[r].busy));
            chk($sformatf("tbl%0d_maddr", r),  32'(mem_addr), 32'(tbl[r].maddr));
            next_cycle();
        end

        // Round robin with all four clients, each releasing after 3 granted cycles.
        reset_dut();
        rq = 4'hF;
        for (int i = 0; i < int'(NR); i++) cnt[i] = 0;
        prev_g = '0; zrun = 0; blen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            req = rq;
            we  = '0;
            @(negedge clk);
            g = gnt;
            if (g != 0) begin
                if (prev_g == 0) begin
                    order.push_back(oh_idx(g));
                    if (order.size() > 1) gaps.push_back(zrun);
                    blen = 0;
                end
                blen++;
                zrun = 0;
            end else begin
                if (prev_g != 0) lens.push_back(blen);
                zrun++;
            end
            prev_g = g;
            for (int i = 0; i < int'(NR); i++) begin
                if (!rq[i]) rq[i] = 1'b1;
                else if (g[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        rq[i] = 1'b0;
                        cnt[i] = 0;
                    end
                end
            end
            next_cycle();
        end
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        chk("rr_enough_bursts", 32'(order.size() >= 5), 32'(1));
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : 99, exp_order[k]);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_gap%0d", k), (k < gaps.size()) ? gaps[k] : 99, 1);
            chk($sformatf("rr_len%0d", k), (k < lens.size()) ? lens[k] : 99, 4);
        end

        // Reset in the middle of a validator read burst.
        reset_dut();
        req = 4'h2; we = '0; addr_flat = {4{6'd3}};
        next_cycle();
        @(negedge clk);
        chk("rst_pre_gnt", 32'(gnt), 32'(4'h2));
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_pre_rvalid", 32'(rvalid), 32'(4'h2));
        next_cycle();
        reset = 1'b0; req = 4'h1; we = 4'hF;
        @(negedge clk);
        chk("rst_gnt",    32'(gnt),    32'(0));
        chk("rst_rvalid", 32'(rvalid), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_busy",   32'(busy),   32'(0));
        next_cycle();
        we = '0;
        @(negedge clk);
        chk("rst_regrant_gnt",   32'(gnt),   32'(4'h1));
        chk("rst_regrant_owner", 32'(owner), 32'(0));
        next_cycle();
        req = '0;
        repeat (3) next_cycle();

`ifdef BOARD_ARB_HOLD_LIMIT_EN
        // View holds its request past the grant limit with control pending.
        begin
            logic [3:0] eh [7];
            eh[0] = 4'h0; eh[1] = 4'h8; eh[2] = 4'h8; eh[3] = 4'h8;
            eh[4] = 4'h8; eh[5] = 4'h0; eh[6] = 4'h1;
            reset_dut();
            for (int c = 0; c < 7; c++) begin
                req = (c == 0) ? 4'h8 : 4'h9;
                @(negedge clk);
                chk($sformatf("hold_gnt%0d", c), 32'(gnt), 32'(eh[c]));
                next_cycle();
            end
            req = '0;
            repeat (3) next_cycle();
        end
`endif

        // Randomised traffic against the reference model.
        reset_dut();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            reset = rst;
            for (int i = 0; i < int'(NR); i++) begin
                if (m_own == i) req[i] = ($urandom_range(0, 9) < 8);
                else            req[i] = ($urandom_range(0, 9) < 4);
                we[i] = ($urandom_range(0, 1) == 1);
                addr_flat[i*AW +: AW]  = AW'($urandom_range(0, 7));
                wdata_flat[i*DW +: DW] = DW'($urandom_range(0, 15));
            end
            @(negedge clk);
            model_check();
            model_step(rst);
            next_cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
